// File: rtl/gpu_ds_pkg.sv
// Shared types and defaults for the depth/stencil fragment arbiter.
package gpu_ds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESPOND   = 3'd4
  } ds_state_e;

  localparam int DS_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/ds_rr_picker.sv
// Circular first-set search: lowest requester at or after i_ptr, wrapping.
module ds_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic               o_valid,
  output logic [IDW-1:0]     o_idx
);

  always_comb begin
    int pos;
    pos     = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_valid && i_req[pos]) begin
        o_valid = 1'b1;
        o_idx   = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/ds_fragment_arbiter.sv
// Round-robin arbiter feeding one fragment at a time to the depth/stencil unit,
// with a per-fragment watchdog and one-hot result return.
//
// state      | meaning
// IDLE       | waiting for enable and a valid requester; grant happens here
// ISSUE      | ds_valid_o up with latched fragment until ds_ready_i
// WAIT_BUSY  | unit accepted, waiting for ds_busy_i to rise
// WAIT_DONE  | unit working, waiting for ds_busy_i to fall
// RESPOND    | one-cycle rsp_valid_o pulse to the granted requester
module ds_fragment_arbiter
  import gpu_ds_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int Z_BUFFER_DEPTH = 24,
  parameter int STENCIL_DEPTH  = 8,
  parameter int TIMEOUT_CYCLES = DS_TIMEOUT_CYCLES
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                enable_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ*32-1:0]               req_x_i,
  input  logic [NUM_REQ*32-1:0]               req_y_i,
  input  logic [NUM_REQ*Z_BUFFER_DEPTH-1:0]   req_depth_i,
  input  logic [NUM_REQ*STENCIL_DEPTH-1:0]    req_stencil_i,
  output logic [31:0]                         ds_x_o,
  output logic [31:0]                         ds_y_o,
  output logic [Z_BUFFER_DEPTH-1:0]           ds_depth_o,
  output logic [STENCIL_DEPTH-1:0]            ds_stencil_o,
  output logic                                ds_valid_o,
  input  logic                                ds_ready_i,
  input  logic                                ds_busy_i,
  input  logic                                ds_all_pass_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic                                rsp_pass_o,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id_o,
  output logic                                timeout_err_o,
  output logic                                busy_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]      WD_LOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);

  ds_state_e                   r_state;
  logic [IDW-1:0]              r_rr_ptr;
  logic [IDW-1:0]              r_gid;
  logic [31:0]                 r_x;
  logic [31:0]                 r_y;
  logic [Z_BUFFER_DEPTH-1:0]   r_depth;
  logic [STENCIL_DEPTH-1:0]    r_stencil;
  logic                        r_ds_valid;
  logic [NUM_REQ-1:0]          r_rsp_valid;
  logic                        r_result;
  logic                        r_timeout_err;
  logic [CW-1:0]               r_wd_cnt;
  logic                        r_rst_done;

  logic                        w_pick_valid;
  logic [IDW-1:0]              w_pick_idx;
  logic                        w_grant;
  logic                        w_wd_tc;

  ds_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // r_rst_done keeps the combinational accept pulse low while reset is held
  assign w_grant = r_rst_done && (r_state == ST_IDLE) && enable_i && w_pick_valid;
  assign w_wd_tc = (r_wd_cnt == '0);

  assign req_ready_o   = w_grant ? (ONE_HOT << w_pick_idx) : '0;
  assign ds_x_o        = r_x;
  assign ds_y_o        = r_y;
  assign ds_depth_o    = r_depth;
  assign ds_stencil_o  = r_stencil;
  assign ds_valid_o    = r_ds_valid;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_pass_o    = (r_state == ST_RESPOND) && r_result;
  assign grant_id_o    = r_gid;
  assign timeout_err_o = r_timeout_err;
  assign busy_o        = (r_state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_gid         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_depth       <= '0;
      r_stencil     <= '0;
      r_ds_valid    <= 1'b0;
      r_rsp_valid   <= '0;
      r_result      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wd_cnt      <= '0;
      r_rst_done    <= 1'b0;
    end else begin
      r_rst_done  <= 1'b1;
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_gid      <= w_pick_idx;
            r_rr_ptr   <= (int'(w_pick_idx) == NUM_REQ - 1) ? '0 : w_pick_idx + 1'b1;
            r_x        <= req_x_i[int'(w_pick_idx)*32 +: 32];
            r_y        <= req_y_i[int'(w_pick_idx)*32 +: 32];
            r_depth    <= req_depth_i[int'(w_pick_idx)*Z_BUFFER_DEPTH +: Z_BUFFER_DEPTH];
            r_stencil  <= req_stencil_i[int'(w_pick_idx)*STENCIL_DEPTH +: STENCIL_DEPTH];
            r_ds_valid <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ds_ready_i) begin
            r_ds_valid <= 1'b0;
            r_wd_cnt   <= WD_LOAD;
            r_state    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (w_wd_tc) begin
            r_timeout_err <= 1'b1;
            r_result      <= 1'b0;
            r_rsp_valid   <= ONE_HOT << r_gid;
            r_state       <= ST_RESPOND;
          end else begin
            r_wd_cnt <= r_wd_cnt - 1'b1;
            if (ds_busy_i) r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // watchdog wins a tie with completion so the error is never masked
          if (w_wd_tc) begin
            r_timeout_err <= 1'b1;
            r_result      <= 1'b0;
            r_rsp_valid   <= ONE_HOT << r_gid;
            r_state       <= ST_RESPOND;
          end else begin
            r_wd_cnt <= r_wd_cnt - 1'b1;
            if (!ds_busy_i) begin
              r_result    <= ds_all_pass_i;
              r_rsp_valid <= ONE_HOT << r_gid;
              r_state     <= ST_RESPOND;
            end
          end
        end
        ST_RESPOND: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ds_fragment_arbiter.sv
// Directed bench for ds_fragment_arbiter with a small behavioural depth/stencil unit.
module tb_ds_fragment_arbiter;

  localparam int NR = 4;
  localparam int ZD = 24;
  localparam int SD = 8;
  localparam int TO = 16;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              enable_i = 1'b0;
  logic [NR-1:0]     req_valid_i = '0;
  logic [NR-1:0]     req_ready_o;
  logic [NR*32-1:0]  req_x_i;
  logic [NR*32-1:0]  req_y_i;
  logic [NR*ZD-1:0]  req_depth_i;
  logic [NR*SD-1:0]  req_stencil_i;
  logic [31:0]       ds_x_o;
  logic [31:0]       ds_y_o;
  logic [ZD-1:0]     ds_depth_o;
  logic [SD-1:0]     ds_stencil_o;
  logic              ds_valid_o;
  logic              ds_ready_i = 1'b1;
  logic              ds_busy_i = 1'b0;
  logic              ds_all_pass_i = 1'b1;
  logic [NR-1:0]     rsp_valid_o;
  logic              rsp_pass_o;
  logic [1:0]        grant_id_o;
  logic              timeout_err_o;
  logic              busy_o;

  ds_fragment_arbiter #(
    .NUM_REQ        (NR),
    .Z_BUFFER_DEPTH (ZD),
    .STENCIL_DEPTH  (SD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .enable_i      (enable_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_x_i       (req_x_i),
    .req_y_i       (req_y_i),
    .req_depth_i   (req_depth_i),
    .req_stencil_i (req_stencil_i),
    .ds_x_o        (ds_x_o),
    .ds_y_o        (ds_y_o),
    .ds_depth_o    (ds_depth_o),
    .ds_stencil_o  (ds_stencil_o),
    .ds_valid_o    (ds_valid_o),
    .ds_ready_i    (ds_ready_i),
    .ds_busy_i     (ds_busy_i),
    .ds_all_pass_i (ds_all_pass_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_pass_o    (rsp_pass_o),
    .grant_id_o    (grant_id_o),
    .timeout_err_o (timeout_err_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Unit model: after a handshake, ds_busy_i is high for unit_busy_len cycles.
  int   busy_left = 0;
  int   unit_busy_len = 3;
  logic unit_en = 1'b1;

  always @(negedge clk_i) begin
    #2;
    if (busy_left > 0) begin
      ds_busy_i = 1'b1;
      busy_left--;
    end else begin
      ds_busy_i = 1'b0;
    end
    if (unit_en && ds_valid_o && ds_ready_i) busy_left = unit_busy_len;
  end

  // Monitor: accept pulses, result pulses and unit handshakes.
  logic [NR-1:0] grant_q[$];
  logic [NR-1:0] rsp_q[$];
  logic          pass_q[$];
  int            hs_cnt = 0;

  always @(negedge clk_i) begin
    #1;
    if (req_ready_o != '0) grant_q.push_back(req_ready_o);
    if (rsp_valid_o != '0) begin
      rsp_q.push_back(rsp_valid_o);
      pass_q.push_back(rsp_pass_o);
    end
    if (ds_valid_o && ds_ready_i) hs_cnt++;
  end

  task automatic clear_mon();
    grant_q.delete();
    rsp_q.delete();
    pass_q.delete();
    hs_cnt = 0;
  endtask

  task automatic wait_rsp(input int budget, output int cyc);
    cyc = 0;
    while (rsp_q.size() == 0 && cyc < budget) begin
      @(negedge clk_i); #3;
      cyc++;
    end
  endtask

  task automatic check_rsp(input string tag, input logic [NR-1:0] exp_id, input logic exp_pass);
    check({tag, "_seen"}, rsp_q.size(), 1);
    if (rsp_q.size() > 0) begin
      check({tag, "_id"}, rsp_q[0], exp_id);
      check({tag, "_pass"}, pass_q[0], exp_pass);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int cyc;
    int n;
    logic [NR-1:0] e;

    for (int i = 0; i < NR; i++) begin
      req_x_i[i*32 +: 32]     = 32'hA000_0000 + i;
      req_y_i[i*32 +: 32]     = 32'hB000_0000 + i;
      req_depth_i[i*ZD +: ZD] = 24'hC0_0000 + i;
      req_stencil_i[i*SD +: SD] = 8'h10 + 8'(i);
    end

    // reset: outputs quiet even with every requester valid
    enable_i    = 1'b1;
    req_valid_i = 4'hF;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_ctl", {ds_valid_o, req_ready_o, rsp_valid_o, rsp_pass_o, grant_id_o, timeout_err_o, busy_o}, '0);
    check("rst_fields", {ds_x_o, ds_depth_o}, '0);
    @(negedge clk_i);
    req_valid_i = '0;
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // single request from requester 2, unit busy 3 cycles, pass
    clear_mon();
    req_valid_i = 4'b0100;
    #1;
    check("t1_ready", req_ready_o, 4'b0100);
    check("t1_busy_idle", busy_o, 0);
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    check("t1_ready_drop", req_ready_o, 0);
    check("t1_ds_valid", ds_valid_o, 1);
    check("t1_fields", {ds_x_o, ds_y_o, ds_depth_o, ds_stencil_o},
          {32'hA000_0002, 32'hB000_0002, 24'hC0_0002, 8'h12});
    check("t1_gid", grant_id_o, 2);
    check("t1_busy", busy_o, 1);
    wait_rsp(40, cyc);
    check("t1_latency", cyc + 1, 6);
    check_rsp("t1_rsp", 4'b0100, 1'b1);
    @(negedge clk_i); #3;
    check("t1_rsp_one_cycle", rsp_valid_o, 0);
    check("t1_back_idle", busy_o, 0);
    check("t1_rsp_count", rsp_q.size(), 1);
    check("t1_handshakes", hs_cnt, 1);

    // ds_ready_i low for 10 cycles in ISSUE; result fails
    clear_mon();
    ds_ready_i    = 1'b0;
    ds_all_pass_i = 1'b0;
    req_valid_i   = 4'b0001;
    #1;
    check("t2_ready", req_ready_o, 4'b0001);
    @(negedge clk_i);
    req_valid_i = '0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("t2_hold%0d", k), {ds_valid_o, ds_x_o, ds_depth_o}, {1'b1, 32'hA000_0000, 24'hC0_0000});
      @(negedge clk_i);
    end
    ds_ready_i = 1'b1;
    #1;
    check("t2_still_valid", ds_valid_o, 1);
    @(negedge clk_i); #1;
    check("t2_valid_drop", ds_valid_o, 0);
    wait_rsp(40, cyc);
    check_rsp("t2_rsp", 4'b0001, 1'b0);
    check("t2_handshakes", hs_cnt, 1);

    // enable low blocks grants; dropping it mid-fragment does not abort
    clear_mon();
    ds_all_pass_i = 1'b1;
    enable_i      = 1'b0;
    req_valid_i   = 4'b0010;
    repeat (5) @(negedge clk_i);
    #3;
    check("t3_no_grant", grant_q.size(), 0);
    check("t3_idle", busy_o, 0);
    @(negedge clk_i);
    enable_i = 1'b1;
    #1;
    check("t3_ready", req_ready_o, 4'b0010);
    @(negedge clk_i);
    enable_i    = 1'b0;
    req_valid_i = '0;
    wait_rsp(40, cyc);
    check_rsp("t3_rsp", 4'b0010, 1'b1);
    check("t3_grants", grant_q.size(), 1);
    enable_i = 1'b1;

    // all four valid continuously from reset: round-robin 0,1,2,3,0
    @(negedge clk_i);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    clear_mon();
    req_valid_i = 4'hF;
    rst_n_i = 1'b1;
    cyc = 0;
    while (rsp_q.size() < 5 && cyc < 100) begin
      @(negedge clk_i); #3;
      cyc++;
    end
    req_valid_i = '0;
    check("t4_rsp_count", rsp_q.size() >= 5, 1);
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      if (k < grant_q.size()) check($sformatf("t4_grant%0d", k), grant_q[k], e);
      if (k < rsp_q.size())   check($sformatf("t4_rsp%0d", k), rsp_q[k], e);
    end
    repeat (3) @(negedge clk_i);

    // unit never goes busy: watchdog fires after TO cycles of waiting
    clear_mon();
    unit_en     = 1'b0;
    req_valid_i = 4'b1000;
    #1;
    check("t5_ready", req_ready_o, 4'b1000);
    @(negedge clk_i);
    req_valid_i = '0;
    n = 1;
    while (rsp_q.size() == 0 && n < 60) begin
      @(negedge clk_i); #3;
      n++;
      if (n == 17) check("t5_err_before", timeout_err_o, 0);
    end
    check("t5_rsp_cycle", n, 18);
    check_rsp("t5_rsp", 4'b1000, 1'b0);
    check("t5_err_set", timeout_err_o, 1);
    repeat (5) @(negedge clk_i);
    #1;
    check("t5_err_sticky", timeout_err_o, 1);
    unit_en = 1'b1;

    // reset during WAIT_DONE drops the fragment; rr pointer restarts at 0
    clear_mon();
    unit_busy_len = 20;
    req_valid_i   = 4'b0100;
    #1;
    check("t6_ready", req_ready_o, 4'b0100);
    @(negedge clk_i);
    req_valid_i = '0;
    repeat (4) @(negedge clk_i);
    #1;
    check("t6_mid_busy", {busy_o, timeout_err_o}, 2'b11);
    rst_n_i   = 1'b0;
    busy_left = 0;
    #1;
    check("t6_rst_outs", {ds_valid_o, req_ready_o, rsp_valid_o, rsp_pass_o, grant_id_o, timeout_err_o, busy_o}, '0);
    repeat (3) @(negedge clk_i);
    #3;
    check("t6_no_rsp", rsp_q.size(), 0);
    unit_busy_len = 3;
    @(negedge clk_i);
    rst_n_i     = 1'b1;
    req_valid_i = 4'b1001;
    cyc = 0;
    while (grant_q.size() == 0 && cyc < 10) begin
      @(negedge clk_i); #3;
      cyc++;
    end
    check("t6_grant_seen", grant_q.size(), 1);
    if (grant_q.size() > 0) check("t6_grant_id", grant_q[0], 4'b0001);
    @(negedge clk_i);
    req_valid_i = '0;
    wait_rsp(40, cyc);
    check_rsp("t6_rsp", 4'b0001, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
